// File: rtl/trap_ctrl_pkg.sv
// Shared types, CSR addresses, interrupt codes and mstatus update helpers for trap_ctrl.
package trap_ctrl_pkg;

    localparam int unsigned CSR_XLEN = 64;
    localparam int unsigned CSR_AW   = 12;
    localparam int unsigned CODE_W   = 6;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;
    localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;

    localparam logic [CODE_W-1:0] IRQ_MEI = 6'd11;
    localparam logic [CODE_W-1:0] IRQ_MSI = 6'd3;
    localparam logic [CODE_W-1:0] IRQ_MTI = 6'd7;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M    = 2'b11;
    localparam logic [1:0] PRIV_RSVD = 2'b10;

    typedef enum logic [2:0] {
        IDLE, FLUSH, W_EPC, W_CAUSE, W_TVAL, W_STATUS, W_MRET, REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        EXC, IRQ, MRET
    } trap_kind_t;

    typedef struct packed {
        logic [1:0]          mode;
        logic [CSR_XLEN-1:0] mstatus;
        logic [CSR_XLEN-1:0] mie;
        logic [CSR_XLEN-1:0] mtvec;
        logic [CSR_XLEN-1:0] mepc;
        logic [CSR_XLEN-1:0] mip;
    } csrs_t;

    // mstatus image written on trap entry: stack MIE into MPIE, disable, record prior mode.
    function automatic logic [CSR_XLEN-1:0] trap_mstatus(input logic [CSR_XLEN-1:0] mstatus,
                                                         input logic [1:0]          mode);
        logic [CSR_XLEN-1:0] s;
        s = mstatus;
        s[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
        s[MSTATUS_MIE]  = 1'b0;
        s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mode;
        return s;
    endfunction

    // mstatus image written on mret: restore MIE from MPIE, then MPIE=1, MPP=0.
    function automatic logic [CSR_XLEN-1:0] mret_mstatus(input logic [CSR_XLEN-1:0] mstatus);
        logic [CSR_XLEN-1:0] s;
        s = mstatus;
        s[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
        s[MSTATUS_MPIE] = 1'b1;
        s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        return s;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Fixed-priority machine interrupt selector: MEI > MSI > MTI.
module trap_ctrl_irq_prio
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0]   irq_pend,
    output logic              valid_c,
    output logic [CODE_W-1:0] code_c
);

    always_comb begin
        valid_c = 1'b0;
        code_c  = '0;
        if (irq_pend[IRQ_MEI]) begin
            valid_c = 1'b1;
            code_c  = IRQ_MEI;
        end else if (irq_pend[IRQ_MSI]) begin
            valid_c = 1'b1;
            code_c  = IRQ_MSI;
        end else if (irq_pend[IRQ_MTI]) begin
            valid_c = 1'b1;
            code_c  = IRQ_MTI;
        end
    end

    // Only the three standard machine interrupt lines participate.
    logic unused_bits;
    assign unused_bits = ^{irq_pend[XLEN-1:12], irq_pend[10:8], irq_pend[6:4], irq_pend[2:0]};

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer: drain, write CSRs one per cycle, redirect fetch.
// Optional: define TRAP_VECTORED_EN to honour vectored mtvec mode for interrupts.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter logic [1:0]  RESET_MODE = 2'b11
) (
    input  logic              clk,
    input  logic              reset,
    input  csrs_t             csr_i,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic              exc_valid,
    input  logic [CODE_W-1:0] exc_cause,
    input  logic [XLEN-1:0]   exc_tval,
    input  logic              mret_valid,
    output logic              busy,
    output logic              flush_req,
    input  logic              flush_ack,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              mode_we,
    output logic [1:0]        mode_wdata,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    trap_state_t       state_q, state_d;
    trap_kind_t        kind_q, kind_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   tval_q, tval_d;

    logic [XLEN-1:0]   irq_pend;
    logic              irq_valid;
    logic [CODE_W-1:0] irq_code;
    logic [XLEN-1:0]   trap_base;
    logic [XLEN-1:0]   trap_target;
    logic [1:0]        mpp;

    assign irq_pend = csr_i.mip & csr_i.mie & {XLEN{csr_i.mstatus[MSTATUS_MIE]}};

    trap_ctrl_irq_prio #(.XLEN(XLEN)) u_irq_prio (
        .irq_pend (irq_pend),
        .valid_c  (irq_valid),
        .code_c   (irq_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            kind_q  <= EXC;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
        end
    end

    // Next state and event capture; commit inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        case (state_q)
            IDLE: begin
                if (commit_valid) begin
                    if (exc_valid) begin
                        state_d = FLUSH;
                        kind_d  = EXC;
                        epc_d   = commit_pc;
                        cause_d = XLEN'(exc_cause);
                        tval_d  = exc_tval;
                    end else if (mret_valid) begin
                        state_d = FLUSH;
                        kind_d  = MRET;
                        epc_d   = commit_pc;
                        cause_d = '0;
                        tval_d  = '0;
                    end else if (irq_valid) begin
                        state_d = FLUSH;
                        kind_d  = IRQ;
                        epc_d   = commit_pc;
                        cause_d = {1'b1, {(XLEN-1-CODE_W){1'b0}}, irq_code};
                        tval_d  = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_ack) begin
                    state_d = (kind_q == MRET) ? W_MRET : W_EPC;
                end
            end
            W_EPC:    state_d = W_CAUSE;
            W_CAUSE:  state_d = W_TVAL;
            W_TVAL:   state_d = W_STATUS;
            W_STATUS: state_d = REDIRECT;
            W_MRET:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign trap_base = {csr_i.mtvec[XLEN-1:2], 2'b00};
    assign mpp       = csr_i.mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

    always_comb begin
        trap_target = trap_base;
`ifdef TRAP_VECTORED_EN
        if (kind_q == IRQ && csr_i.mtvec[1:0] == 2'b01) begin
            trap_target = trap_base + XLEN'({cause_q[CODE_W-1:0], 2'b00});
        end
`endif
    end

    // Moore output decode: every strobe is tied to exactly one state.
    always_comb begin
        busy           = (state_q != IDLE);
        flush_req      = 1'b0;
        csr_we         = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        mode_we        = 1'b0;
        mode_wdata     = 2'b00;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            FLUSH: flush_req = 1'b1;
            W_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = {epc_q[XLEN-1:2], 2'b00};
            end
            W_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = cause_q;
            end
            W_TVAL: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MTVAL;
                csr_wdata = tval_q;
            end
            W_STATUS: begin
                csr_we     = 1'b1;
                csr_addr   = CSR_MSTATUS;
                csr_wdata  = trap_mstatus(csr_i.mstatus, csr_i.mode);
                mode_we    = 1'b1;
                mode_wdata = PRIV_M;
            end
            W_MRET: begin
                csr_we     = 1'b1;
                csr_addr   = CSR_MSTATUS;
                csr_wdata  = mret_mstatus(csr_i.mstatus);
                mode_we    = 1'b1;
                mode_wdata = (mpp == PRIV_RSVD) ? RESET_MODE : mpp;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = (kind_q == MRET) ? csr_i.mepc : trap_target;
            end
            default: ;
        endcase
    end

    logic unused_bits;
`ifdef TRAP_VECTORED_EN
    assign unused_bits = ^epc_q[1:0];
`else
    assign unused_bits = ^{epc_q[1:0], csr_i.mtvec[1:0]};
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand sequences, randomized vectors vs model.
module tb_trap_ctrl;

    logic                  clk = 1'b0;
    logic                  reset;
    trap_ctrl_pkg::csrs_t  csr_i;
    logic                  commit_valid;
    logic [63:0]           commit_pc;
    logic                  exc_valid;
    logic [5:0]            exc_cause;
    logic [63:0]           exc_tval;
    logic                  mret_valid;
    logic                  busy;
    logic                  flush_req;
    logic                  flush_ack;
    logic                  csr_we;
    logic [11:0]           csr_addr;
    logic [63:0]           csr_wdata;
    logic                  mode_we;
    logic [1:0]            mode_wdata;
    logic                  redirect_valid;
    logic [63:0]           redirect_pc;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .csr_i          (csr_i),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .busy           (busy),
        .flush_req      (flush_req),
        .flush_ack      (flush_ack),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .mode_we        (mode_we),
        .mode_wdata     (mode_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] pc;
        logic        exc_v;
        logic [5:0]  exc_c;
        logic [63:0] tval;
        logic        mret_v;
        logic [63:0] mstatus;
        logic [63:0] mie;
        logic [63:0] mip;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic [1:0]  mode;
        int          dly;
        logic [63:0] e_epc;
        logic [63:0] e_cause;
        logic [63:0] e_tval;
        logic [63:0] e_status;
        logic [1:0]  e_mode;
        logic [63:0] e_redir;
        int          e_lat;
    } vec_t;

    function automatic vec_t mkin(input logic [63:0] pc, input logic exc_v, input logic [5:0] exc_c,
                                  input logic [63:0] tval, input logic mret_v, input logic [63:0] mstatus,
                                  input logic [63:0] mie, input logic [63:0] mip, input logic [63:0] mtvec,
                                  input logic [63:0] mepc, input logic [1:0] mode, input int dly);
        vec_t v;
        v = '{default: '0};
        v.pc = pc; v.exc_v = exc_v; v.exc_c = exc_c; v.tval = tval; v.mret_v = mret_v;
        v.mstatus = mstatus; v.mie = mie; v.mip = mip; v.mtvec = mtvec; v.mepc = mepc;
        v.mode = mode; v.dly = dly;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t vi, input logic [63:0] epc, input logic [63:0] cause,
                                      input logic [63:0] tval, input logic [63:0] status,
                                      input logic [1:0] mode, input logic [63:0] redir, input int lat);
        vec_t v;
        v = vi;
        v.e_epc = epc; v.e_cause = cause; v.e_tval = tval; v.e_status = status;
        v.e_mode = mode; v.e_redir = redir; v.e_lat = lat;
        return v;
    endfunction

    // Reference model: derives the whole expected transaction from the architectural rules.
    function automatic vec_t predict(input vec_t vi);
        vec_t        v;
        logic [63:0] pend;
        logic [63:0] base;
        int          code;
        logic        is_irq;
        v      = vi;
        pend   = vi.mstatus[3] ? (vi.mip & vi.mie) : 64'd0;
        code   = pend[11] ? 11 : pend[3] ? 3 : pend[7] ? 7 : 0;
        is_irq = !vi.exc_v && !vi.mret_v;
        base   = vi.mtvec - (vi.mtvec % 64'd4);
        v.e_epc = vi.pc - (vi.pc % 64'd4);
        if (vi.mret_v && !vi.exc_v) begin
            v.e_cause  = 64'd0;
            v.e_tval   = 64'd0;
            v.e_status = (vi.mstatus & ~64'h1888) | (64'(vi.mstatus[7]) << 3) | 64'h80;
            v.e_mode   = (vi.mstatus[12:11] == 2'b10) ? 2'b11 : vi.mstatus[12:11];
            v.e_redir  = vi.mepc;
            v.e_lat    = 3 + vi.dly;
        end else begin
            v.e_cause  = is_irq ? (64'h8000_0000_0000_0000 + 64'(code)) : 64'(vi.exc_c);
            v.e_tval   = is_irq ? 64'd0 : vi.tval;
            v.e_status = (vi.mstatus & ~64'h1888) | (64'(vi.mstatus[3]) << 7) | (64'(vi.mode) << 11);
            v.e_mode   = 2'b11;
            v.e_redir  = base;
`ifdef TRAP_VECTORED_EN
            if (is_irq && vi.mtvec % 64'd4 == 64'd1) v.e_redir = base + 64'(4 * code);
`endif
            v.e_lat    = 6 + vi.dly;
        end
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".busy"},      64'(busy), 64'd0);
        chk({tag, ".flush_req"}, 64'(flush_req), 64'd0);
        chk({tag, ".csr_we"},    64'(csr_we), 64'd0);
        chk({tag, ".csr_addr"},  64'(csr_addr), 64'd0);
        chk({tag, ".csr_wdata"}, csr_wdata, 64'd0);
        chk({tag, ".mode_we"},   64'(mode_we), 64'd0);
        chk({tag, ".mode_wd"},   64'(mode_wdata), 64'd0);
        chk({tag, ".redir_v"},   64'(redirect_valid), 64'd0);
        chk({tag, ".redir_pc"},  redirect_pc, 64'd0);
    endtask

    // Present one committing event, then watch the transaction until the redirect pulse.
    task automatic run_vec(input vec_t v, input string tag);
        logic [11:0] got_a[$];
        logic [63:0] got_d[$];
        logic [11:0] ea[4];
        logic [63:0] ed[4];
        int          n_exp;
        int          got_lat;
        logic [63:0] got_pc;
        int          mode_cnt;
        logic [1:0]  mode_val;
        logic        is_mret;
        is_mret  = v.mret_v && !v.exc_v;
        got_lat  = -1;
        got_pc   = 64'd0;
        mode_cnt = 0;
        mode_val = 2'b00;
        @(negedge clk);
        csr_i.mode = v.mode; csr_i.mstatus = v.mstatus; csr_i.mie = v.mie;
        csr_i.mip = v.mip; csr_i.mtvec = v.mtvec; csr_i.mepc = v.mepc;
        commit_valid = 1'b1; commit_pc = v.pc;
        exc_valid = v.exc_v; exc_cause = v.exc_c; exc_tval = v.tval; mret_valid = v.mret_v;
        flush_ack = (v.dly == 0);
        chk({tag, ".idle_before"}, 64'(busy), 64'd0);
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk({tag, ".busy"}, 64'(busy), 64'd1);
            chk({tag, ".flush_req"}, 64'(flush_req), 64'(c <= v.dly + 1));
            if (csr_we) begin
                got_a.push_back(csr_addr);
                got_d.push_back(csr_wdata);
            end
            if (mode_we) begin
                mode_cnt++;
                mode_val = mode_wdata;
            end
            // Garbage commits while busy must be ignored.
            commit_valid = 1'b1;
            exc_valid    = 1'($urandom % 2);
            mret_valid   = 1'($urandom % 2);
            exc_cause    = 6'($urandom);
            commit_pc    = {$urandom, $urandom};
            flush_ack    = (c >= v.dly + 1);
            if (redirect_valid) begin
                got_lat = c;
                got_pc  = redirect_pc;
                commit_valid = 1'b0; exc_valid = 1'b0; mret_valid = 1'b0;
                break;
            end
        end
        if (is_mret) begin
            n_exp = 1;
            ea[0] = 12'h300; ed[0] = v.e_status;
        end else begin
            n_exp = 4;
            ea[0] = 12'h341; ed[0] = v.e_epc;
            ea[1] = 12'h342; ed[1] = v.e_cause;
            ea[2] = 12'h343; ed[2] = v.e_tval;
            ea[3] = 12'h300; ed[3] = v.e_status;
        end
        chk({tag, ".latency"}, 64'(got_lat), 64'(v.e_lat));
        chk({tag, ".redirect_pc"}, got_pc, v.e_redir);
        chk({tag, ".n_writes"}, 64'(got_a.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < got_a.size(); i++) begin
            chk($sformatf("%s.w%0d_addr", tag, i), 64'(got_a[i]), 64'(ea[i]));
            chk($sformatf("%s.w%0d_data", tag, i), got_d[i], ed[i]);
        end
        chk({tag, ".n_mode_we"}, 64'(mode_cnt), 64'd1);
        chk({tag, ".mode"}, 64'(mode_val), 64'(v.e_mode));
        @(negedge clk);
        chk({tag, ".idle_after"}, 64'(busy), 64'd0);
        chk({tag, ".redir_pulse"}, 64'(redirect_valid), 64'd0);
    endtask

    localparam logic [63:0] TV = 64'h8000_0100;
`ifdef TRAP_VECTORED_EN
    localparam logic [63:0] VEC_MEI = 64'h8000_012C;
`else
    localparam logic [63:0] VEC_MEI = 64'h8000_0100;
`endif

    vec_t tbl[11];

    initial begin
        tbl[0]  = with_exp(mkin(64'h8000_0010, 1, 6'd2, 64'h13, 0, 64'h8, 0, 0, TV, 0, 2'd3, 0),
                           64'h8000_0010, 64'd2, 64'h13, 64'h1880, 2'd3, TV, 6);
        tbl[1]  = with_exp(mkin(64'h8000_0200, 0, 6'd0, 64'h0, 0, 64'h8, 64'h80, 64'h80, TV, 0, 2'd3, 0),
                           64'h8000_0200, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 2'd3, TV, 6);
        tbl[2]  = with_exp(mkin(64'h8000_0300, 1, 6'd5, 64'hdead, 0, 64'h8, 64'h888, 64'h888, TV, 0, 2'd3, 0),
                           64'h8000_0300, 64'd5, 64'hdead, 64'h1880, 2'd3, TV, 6);
        tbl[3]  = with_exp(mkin(64'h8000_0304, 0, 6'd0, 64'h0, 0, 64'h8, 64'h888, 64'h888, TV, 0, 2'd3, 0),
                           64'h8000_0304, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 2'd3, TV, 6);
        tbl[4]  = with_exp(mkin(64'h8000_0400, 0, 6'd0, 64'h0, 1, 64'h1880, 0, 0, TV, 64'h8000_0014, 2'd3, 0),
                           64'd0, 64'd0, 64'd0, 64'h88, 2'd3, 64'h8000_0014, 3);
        tbl[5]  = with_exp(mkin(64'h8000_0404, 0, 6'd0, 64'h0, 1, 64'h1888, 64'h800, 64'h800, TV, 64'h8000_0014, 2'd3, 0),
                           64'd0, 64'd0, 64'd0, 64'h88, 2'd3, 64'h8000_0014, 3);
        tbl[6]  = with_exp(mkin(64'h8000_0408, 0, 6'd0, 64'h0, 1, 64'h1000, 0, 0, TV, 64'h8000_0020, 2'd3, 0),
                           64'd0, 64'd0, 64'd0, 64'h80, 2'd3, 64'h8000_0020, 3);
        tbl[7]  = with_exp(mkin(64'h8000_040C, 0, 6'd0, 64'h0, 1, 64'hA000_0000_0000_0080, 0, 0, TV, 64'h8000_0030, 2'd3, 1),
                           64'd0, 64'd0, 64'd0, 64'hA000_0000_0000_0088, 2'd0, 64'h8000_0030, 4);
        tbl[8]  = with_exp(mkin(64'h8000_0406, 1, 6'd3, 64'h8000_0406, 1, 64'hFF00, 0, 0, TV, 64'h8000_0014, 2'd1, 2),
                           64'h8000_0404, 64'd3, 64'h8000_0406, 64'hEF00, 2'd3, TV, 8);
        tbl[9]  = with_exp(mkin(64'h8000_0500, 0, 6'd0, 64'h0, 0, 64'h8, 64'h800, 64'h800, 64'h8000_0101, 0, 2'd3, 0),
                           64'h8000_0500, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 2'd3, VEC_MEI, 6);
        tbl[10] = with_exp(mkin(64'h8000_0504, 1, 6'd4, 64'h77, 0, 64'h8, 0, 0, 64'h8000_0101, 0, 2'd3, 0),
                           64'h8000_0504, 64'd4, 64'h77, 64'h1880, 2'd3, TV, 6);

        reset = 1'b1; csr_i = '0; commit_valid = 1'b0; commit_pc = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_tval = '0; mret_valid = 1'b0; flush_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // No commit, or commit with interrupts globally masked: stay idle.
        csr_i.mip = 64'h888; csr_i.mie = 64'h888; csr_i.mstatus = 64'h0;
        exc_valid = 1'b1; mret_valid = 1'b1; commit_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_commit.busy", 64'(busy), 64'd0);
        exc_valid = 1'b0; mret_valid = 1'b0; commit_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("masked_irq.busy", 64'(busy), 64'd0);
        commit_valid = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("dir%0d", i));

        // Drain never acknowledged, then reset aborts the sequence.
        @(negedge clk);
        csr_i.mstatus = 64'h8; csr_i.mtvec = TV;
        commit_valid = 1'b1; exc_valid = 1'b1; exc_cause = 6'd2; commit_pc = 64'h8000_0600;
        flush_ack = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            commit_valid = 1'b0; exc_valid = 1'b0;
            chk($sformatf("hold%0d.flush_req", c), 64'(flush_req), 64'd1);
            chk($sformatf("hold%0d.csr_we", c), 64'(csr_we), 64'd0);
            chk($sformatf("hold%0d.busy", c), 64'(busy), 64'd1);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("abort");
        reset = 1'b0; flush_ack = 1'b1;
        run_vec(tbl[0], "after_abort");

        for (int r = 0; r < 40; r++) begin
            vec_t v;
            logic [63:0] mt;
            mt = {$urandom, $urandom};
            mt[1:0] = ($urandom % 2 == 0) ? 2'b01 : 2'b00;
            v = mkin({$urandom, $urandom}, 1'($urandom % 3 == 0), 6'($urandom), {$urandom, $urandom},
                     1'($urandom % 3 == 0), {$urandom, $urandom}, 64'($urandom) & 64'h888,
                     64'($urandom) & 64'h888, mt, {$urandom, $urandom}, 2'($urandom), int'($urandom % 4));
            if (!v.exc_v && !v.mret_v && !(v.mstatus[3] && (v.mie & v.mip) != 64'd0)) v.exc_v = 1'b1;
            run_vec(predict(v), $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Sequences machine-mode trap entry and `mret` return around the CSR register file. It accepts synchronous exceptions, `mret` and pending interrupts at the commit point, and arbitrates between them. It drains the pipeline, then writes mepc/mcause/mtval/mstatus/mode through a single CSR write port, one CSR per cycle. It finally redirects fetch to the trap vector or to mepc.

Parameters:
XLEN, 64, data/PC width
RESET_MODE, 2'b11, privilege mode driven on mode_wdata at mret when MPP is invalid (M-only core)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
csr_i  in  csrs_t  current CSR group (mode, mstatus, mie, mtvec, mepc, mip, ...)
commit_valid  in  1  an instruction is at commit this cycle
commit_pc  in  64  PC of the committing instruction
exc_valid  in  1  committing instruction raised an exception
exc_cause  in  6  exception code
exc_tval  in  64  faulting address/instruction
mret_valid  in  1  committing instruction is mret
busy  out  1  controller not idle; commit stage must stall
flush_req  out  1  request pipeline drain/kill of younger instructions
flush_ack  in  1  pipeline drained (may be asserted in the same cycle as flush_req)
csr_we  out  1  CSR write strobe
csr_addr  out  12  CSR address written
csr_wdata  out  64  CSR write data
mode_we  out  1  privilege mode write strobe
mode_wdata  out  2  new privilege mode
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  64  redirect target

Behaviour:
- Reset: state IDLE; every output 0; latched epc/cause/tval/kind cleared. Reset mid-sequence aborts immediately. Partial CSR writes already done stand.
- irq_pend = mip & mie & {64{mstatus[3]}}. Priority: MEI(11) > MSI(3) > MTI(7).
- Interrupts are sampled only when commit_valid=1. The committing instruction is not retired, and epc = commit_pc.
- Arbitration in IDLE, on commit_valid: exc_valid > mret_valid > irq_pend≠0. Latch kind, epc=commit_pc, cause, tval. Interrupt: tval=0, cause={1'b1, 57'b0, code}. Exception: cause={58'b0, exc_cause}.
- busy = (state≠IDLE). Inputs are ignored while busy.
- States: IDLE → FLUSH → (trap: W_EPC → W_CAUSE → W_TVAL → W_STATUS) | (mret: W_MRET) → REDIRECT → IDLE.
- FLUSH: flush_req=1 and hold until flush_ack=1. Leave FLUSH in the same cycle that ack is seen.
- W_EPC: csr_we=1, addr 0x341, data epc with bits[1:0] forced 0.
- W_CAUSE: addr 0x342, data cause.
- W_TVAL: addr 0x343, data tval.
- W_STATUS: addr 0x300, data = mstatus with MPIE[7]=MIE[3], MIE=0, MPP[12:11]=mode. Also mode_we=1, mode_wdata=2'b11.
- W_MRET: addr 0x300, data = mstatus with MIE=MPIE, MPIE=1, MPP=0. Also mode_we=1, mode_wdata=MPP, or RESET_MODE if MPP=2'b10.
- REDIRECT: redirect_valid=1 for exactly one cycle. Trap target: {mtvec[63:2], 2'b00}. mret target: mepc read from csr_i in this cycle.
- Latency with ack in the first FLUSH cycle: trap redirect 6 cycles after acceptance; mret redirect 3 cycles after acceptance.
- Strobes csr_we, mode_we, redirect_valid and flush_req are 0 in all other states.
- Boundaries:
  - exc and irq in the same cycle → the exception is taken; the irq stays pending in mip.
  - mret together with irq → mret is taken; the irq is re-evaluated after return.
  - Exception raised by the mret instruction → treated as an exception.
  - flush_ack held 0 → remain in FLUSH indefinitely.

Optional Feature:
TRAP_VECTORED_EN
- Defined: if mtvec[1:0]==2'b01 and kind is an interrupt, the trap target is {mtvec[63:2],2'b00} + 4*code. Exceptions still use base.
- Undefined: mtvec[1:0] is ignored and all traps go to base.

Decomposition:
Add to the common package:
- CSR address localparams: MSTATUS, MIE, MTVEC, MEPC, MCAUSE, MTVAL, MIP.
- Interrupt code localparams: IRQ_MEI=11, IRQ_MSI=3, IRQ_MTI=7.
- mstatus bit-index localparams: MIE=3, MPIE=7, MPP=12:11.
- trap_state_t enum (IDLE, FLUSH, W_EPC, W_CAUSE, W_TVAL, W_STATUS, W_MRET, REDIRECT).
- trap_kind_t enum (EXC, IRQ, MRET).

One sub-module, trap_irq_prio: combinational irq_pend → {valid, code[5:0]}.

Test Plan:
- Illegal instruction: commit_pc=0x8000_0010, exc_cause=2, tval=0x0000_0013, mstatus.MIE=1, mode=3, mtvec=0x8000_0100, flush_ack tied 1. Expected: writes mepc=0x8000_0010, mcause=2, mtval=0x13, mstatus MIE=0/MPIE=1/MPP=3. redirect_pc=0x8000_0100 six cycles after acceptance.
- Timer interrupt: mie[7]=mip[7]=1, MIE=1, commit_valid at pc 0x8000_0200. Expected: mcause=0x8000_0000_0000_0007, mtval=0, mepc=0x8000_0200.
- Priority: mip=mie=0x888, plus exc_valid with cause 5 in the same cycle. Expected: mcause=5. On the next commit after return, mcause=0x8000…000B (MEI).
- mret: mstatus MPIE=1/MPP=3, mepc=0x8000_0014. Expected: W_MRET writes MIE=1, MPIE=1, MPP=0; mode_wdata=3; redirect_pc=0x8000_0014 three cycles after acceptance.
- flush_ack held low 5 cycles, then a reset pulse. Expected: flush_req high all 5 cycles, no CSR write. After reset: busy=0 and all outputs 0.
- TRAP_VECTORED_EN defined, mtvec=0x8000_0101, MEI pending. Expected: redirect_pc=0x8000_012C. With the macro undefined: redirect_pc=0x8000_0100.
